// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
// Shared display-geometry constants for the video pipeline. The raster
// generator (vga_timing) and the sprite renderer (draw_sprite) both read
// RES_H/RES_V from here, so visible-area decisions agree everywhere.
// Also provides the helpers used to derive totals and counter widths.
// ---------------------------------------------------------------------------
package vga_timing_pkg;

    // System clocks per pixel (100 MHz system clock -> 25 MHz pixel rate).
    localparam int unsigned CLK_DIV = 32'd4;

    // Horizontal geometry, in pixels.
    localparam int unsigned RES_H  = 32'd640;
    localparam int unsigned H_FP   = 32'd16;
    localparam int unsigned H_SYNC = 32'd96;
    localparam int unsigned H_BP   = 32'd48;

    // Vertical geometry, in lines.
    localparam int unsigned RES_V  = 32'd480;
    localparam int unsigned V_FP   = 32'd10;
    localparam int unsigned V_SYNC = 32'd2;
    localparam int unsigned V_BP   = 32'd33;

    // Full period of one axis including blanking.
    function automatic int unsigned calc_total(input int unsigned active,
                                               input int unsigned fp,
                                               input int unsigned sync,
                                               input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    // Bits needed to count 0..total-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned total);
        return (total > 32'd1) ? $clog2(total) : 32'd1;
    endfunction

    localparam int unsigned H_TOTAL = calc_total(RES_H, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = calc_total(RES_V, V_FP, V_SYNC, V_BP);

endpackage

// File: rtl/vga_timing_pix_clk_div.sv
// ---------------------------------------------------------------------------
// pix_clk_div
// Divides the system clock down to the pixel rate.
//   clk_i       system clock
//   rst_ni      asynchronous active-low reset
//   pix_tick_o  registered one-clk pulse, first clk of every pixel period
//   wrap_o      high in the clk whose closing edge starts a new pixel; the
//               raster counters advance on that same edge so they change
//               together with pix_tick_o
// ---------------------------------------------------------------------------
module pix_clk_div #(
    parameter int unsigned CLK_DIV = vga_timing_pkg::CLK_DIV
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic pix_tick_o,
    output logic wrap_o
);
    import vga_timing_pkg::*;

    localparam int unsigned DIV_W = cnt_width(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 32'd1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(32'd1);
    localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(32'd0);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             tick_q;

    // With CLK_DIV = 1 the divider sits at 0 == DIV_LAST, so wrap is constant.
    assign wrap_o     = (div_q == DIV_LAST);
    assign pix_tick_o = tick_q;

    // Next divider phase: count up, return to zero after the last phase.
    always_comb begin
        div_d = div_q;
        if (wrap_o) begin
            div_d = DIV_ZERO;
        end else begin
            div_d = div_q + DIV_ONE;
        end
    end

    // Divider phase and registered tick.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q  <= DIV_ZERO;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            tick_q <= wrap_o;
        end
    end

endmodule

// File: rtl/vga_timing.sv
// ---------------------------------------------------------------------------
// vga_timing
// Raster timing generator: pixel/line counters, sync and blanking decodes.
//   clk_i          system clock, all state changes on the rising edge
//   rst_ni         asynchronous active-low reset
//   pix_tick_o     one-clk pulse at the start of every pixel period
//   pixel_x_o      current column 0..H_TOTAL-1 (blanking included)
//   pixel_y_o      current line   0..V_TOTAL-1 (blanking included)
//   hsync_o        horizontal sync, active low
//   vsync_o        vertical sync, active low
//   video_en_o     high while inside the visible RES_H x RES_V window
//   frame_start_o  one-clk pulse on entry to (0,0)
//   line_start_o   one-clk pulse on entry to any column 0
// All outputs come straight from flops. Sync/enable/pulse registers are
// loaded from the *next* counter values so they change in the same clk as
// the coordinates they describe.
// ---------------------------------------------------------------------------
module vga_timing #(
    parameter int unsigned CLK_DIV = vga_timing_pkg::CLK_DIV,
    parameter int unsigned RES_H   = vga_timing_pkg::RES_H,
    parameter int unsigned H_FP    = vga_timing_pkg::H_FP,
    parameter int unsigned H_SYNC  = vga_timing_pkg::H_SYNC,
    parameter int unsigned H_BP    = vga_timing_pkg::H_BP,
    parameter int unsigned RES_V   = vga_timing_pkg::RES_V,
    parameter int unsigned V_FP    = vga_timing_pkg::V_FP,
    parameter int unsigned V_SYNC  = vga_timing_pkg::V_SYNC,
    parameter int unsigned V_BP    = vga_timing_pkg::V_BP,
    localparam int unsigned H_TOTAL = vga_timing_pkg::calc_total(RES_H, H_FP, H_SYNC, H_BP),
    localparam int unsigned V_TOTAL = vga_timing_pkg::calc_total(RES_V, V_FP, V_SYNC, V_BP),
    localparam int unsigned X_W     = vga_timing_pkg::cnt_width(H_TOTAL),
    localparam int unsigned Y_W     = vga_timing_pkg::cnt_width(V_TOTAL)
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    output logic           pix_tick_o,
    output logic [X_W-1:0] pixel_x_o,
    output logic [Y_W-1:0] pixel_y_o,
    output logic           hsync_o,
    output logic           vsync_o,
    output logic           video_en_o,
    output logic           frame_start_o,
    output logic           line_start_o
);
    import vga_timing_pkg::*;

    localparam logic [X_W-1:0] H_LAST   = X_W'(H_TOTAL - 32'd1);
    localparam logic [X_W-1:0] H_ACT    = X_W'(RES_H);
    localparam logic [X_W-1:0] HS_START = X_W'(RES_H + H_FP);
    localparam logic [X_W-1:0] HS_STOP  = X_W'(RES_H + H_FP + H_SYNC);
    localparam logic [X_W-1:0] X_ONE    = X_W'(32'd1);
    localparam logic [X_W-1:0] X_ZERO   = X_W'(32'd0);

    localparam logic [Y_W-1:0] V_LAST   = Y_W'(V_TOTAL - 32'd1);
    localparam logic [Y_W-1:0] V_ACT    = Y_W'(RES_V);
    localparam logic [Y_W-1:0] VS_START = Y_W'(RES_V + V_FP);
    localparam logic [Y_W-1:0] VS_STOP  = Y_W'(RES_V + V_FP + V_SYNC);
    localparam logic [Y_W-1:0] Y_ONE    = Y_W'(32'd1);
    localparam logic [Y_W-1:0] Y_ZERO   = Y_W'(32'd0);

    logic           adv_s;
    logic [X_W-1:0] h_q;
    logic [X_W-1:0] h_d;
    logic [Y_W-1:0] v_q;
    logic [Y_W-1:0] v_d;
    logic           line_wrap_s;
    logic           frame_wrap_s;
    logic           hsync_d;
    logic           vsync_d;
    logic           video_en_d;
    logic           hsync_q;
    logic           vsync_q;
    logic           video_en_q;
    logic           line_start_q;
    logic           frame_start_q;

    pix_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_clk_div (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .pix_tick_o (pix_tick_o),
        .wrap_o     (adv_s)
    );

    // Next raster position; counters hold between pixel ticks.
    always_comb begin
        h_d          = h_q;
        v_d          = v_q;
        line_wrap_s  = 1'b0;
        frame_wrap_s = 1'b0;
        if (adv_s) begin
            if (h_q == H_LAST) begin
                h_d         = X_ZERO;
                line_wrap_s = 1'b1;
                if (v_q == V_LAST) begin
                    v_d          = Y_ZERO;
                    frame_wrap_s = 1'b1;
                end else begin
                    v_d = v_q + Y_ONE;
                end
            end else begin
                h_d = h_q + X_ONE;
            end
        end else begin
            h_d = h_q;
            v_d = v_q;
        end
    end

    // Decode sync and visible window from the position about to be loaded.
    always_comb begin
        hsync_d    = ~((h_d >= HS_START) && (h_d < HS_STOP));
        vsync_d    = ~((v_d >= VS_START) && (v_d < VS_STOP));
        video_en_d = (h_d < H_ACT) && (v_d < V_ACT);
    end

    // Raster state and registered outputs. Reset represents pixel (0,0),
    // which is visible, hence video_en resets high.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            h_q           <= X_ZERO;
            v_q           <= Y_ZERO;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            video_en_q    <= 1'b1;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_en_q    <= video_en_d;
            line_start_q  <= line_wrap_s;
            frame_start_q <= frame_wrap_s;
        end
    end

    assign pixel_x_o     = h_q;
    assign pixel_y_o     = v_q;
    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign video_en_o    = video_en_q;
    assign line_start_o  = line_start_q;
    assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_vga_timing.sv
// Bench: one full-size instance (default geometry, 4 clks/pixel) plus two
// reduced-geometry instances (4 clks/pixel and 1 clk/pixel) so whole frames
// fit in a short run. Expected values come from a model that derives the
// raster from elapsed clocks since reset release with plain arithmetic.
module tb_vga_timing;

    localparam int CD_D = 4;
    localparam int RH_D = 640, HFP_D = 16, HSW_D = 96, HBP_D = 48;
    localparam int RV_D = 480, VFP_D = 10, VSW_D = 2,  VBP_D = 33;

    localparam int CD_S = 4;
    localparam int RH_S = 16, HFP_S = 2, HSW_S = 3, HBP_S = 4;
    localparam int RV_S = 6,  VFP_S = 1, VSW_S = 2, VBP_S = 3;
    localparam int HT_S = RH_S + HFP_S + HSW_S + HBP_S;   // 25
    localparam int VT_S = RV_S + VFP_S + VSW_S + VBP_S;   // 12

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       d_tick, d_hs, d_vs, d_ve, d_fs, d_ls;
    logic [9:0] d_x, d_y;
    logic       s_tick, s_hs, s_vs, s_ve, s_fs, s_ls;
    logic [4:0] s_x;
    logic [3:0] s_y;
    logic       f_tick, f_hs, f_vs, f_ve, f_fs, f_ls;
    logic [4:0] f_x;
    logic [3:0] f_y;

    vga_timing #(.CLK_DIV(CD_D), .RES_H(RH_D), .H_FP(HFP_D), .H_SYNC(HSW_D), .H_BP(HBP_D),
                 .RES_V(RV_D), .V_FP(VFP_D), .V_SYNC(VSW_D), .V_BP(VBP_D)) u_def (
        .clk_i(clk), .rst_ni(rst_n), .pix_tick_o(d_tick), .pixel_x_o(d_x), .pixel_y_o(d_y),
        .hsync_o(d_hs), .vsync_o(d_vs), .video_en_o(d_ve), .frame_start_o(d_fs), .line_start_o(d_ls));

    vga_timing #(.CLK_DIV(CD_S), .RES_H(RH_S), .H_FP(HFP_S), .H_SYNC(HSW_S), .H_BP(HBP_S),
                 .RES_V(RV_S), .V_FP(VFP_S), .V_SYNC(VSW_S), .V_BP(VBP_S)) u_small (
        .clk_i(clk), .rst_ni(rst_n), .pix_tick_o(s_tick), .pixel_x_o(s_x), .pixel_y_o(s_y),
        .hsync_o(s_hs), .vsync_o(s_vs), .video_en_o(s_ve), .frame_start_o(s_fs), .line_start_o(s_ls));

    vga_timing #(.CLK_DIV(1), .RES_H(RH_S), .H_FP(HFP_S), .H_SYNC(HSW_S), .H_BP(HBP_S),
                 .RES_V(RV_S), .V_FP(VFP_S), .V_SYNC(VSW_S), .V_BP(VBP_S)) u_fast (
        .clk_i(clk), .rst_ni(rst_n), .pix_tick_o(f_tick), .pixel_x_o(f_x), .pixel_y_o(f_y),
        .hsync_o(f_hs), .vsync_o(f_vs), .video_en_o(f_ve), .frame_start_o(f_fs), .line_start_o(f_ls));

    // Rising edges seen since reset was last released.
    longint n;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) n <= 0;
        else        n <= n + 1;
    end

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic tick; int x; int y;
        logic hs; logic vs; logic ve; logic fs; logic ls;
    } exp_t;

    // Raster expected after cyc edges since release: pixel index = cyc / cd.
    function automatic exp_t model(longint cyc, int cd, int rh, int hfp, int hsw, int hbp,
                                   int rv, int vfp, int vsw, int vbp);
        exp_t   e;
        longint ht, vt, pix;
        logic   new_pix;
        ht      = rh + hfp + hsw + hbp;
        vt      = rv + vfp + vsw + vbp;
        pix     = cyc / cd;
        e.x     = int'(pix % ht);
        e.y     = int'((pix / ht) % vt);
        new_pix = (cyc > 0) && ((cyc % cd) == 0);
        e.tick  = new_pix;
        e.hs    = !((e.x >= rh + hfp) && (e.x < rh + hfp + hsw));
        e.vs    = !((e.y >= rv + vfp) && (e.y < rv + vfp + vsw));
        e.ve    = (e.x < rh) && (e.y < rv);
        e.ls    = new_pix && (e.x == 0);
        e.fs    = e.ls && (e.y == 0);
        return e;
    endfunction

    function automatic exp_t exp_def(longint cyc);
        return model(cyc, CD_D, RH_D, HFP_D, HSW_D, HBP_D, RV_D, VFP_D, VSW_D, VBP_D);
    endfunction
    function automatic exp_t exp_sml(longint cyc);
        return model(cyc, CD_S, RH_S, HFP_S, HSW_S, HBP_S, RV_S, VFP_S, VSW_S, VBP_S);
    endfunction
    function automatic exp_t exp_fst(longint cyc);
        return model(cyc, 1, RH_S, HFP_S, HSW_S, HBP_S, RV_S, VFP_S, VSW_S, VBP_S);
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_release();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (d_tick !== 1'b0) begin failures++; $display("FAIL reset_tick got %b want 0", d_tick); end
        checks++; if (d_x !== 10'd0)   begin failures++; $display("FAIL reset_x got %0d want 0", d_x); end
        checks++; if (d_y !== 10'd0)   begin failures++; $display("FAIL reset_y got %0d want 0", d_y); end
        checks++; if (d_hs !== 1'b1)   begin failures++; $display("FAIL reset_hsync got %b want 1", d_hs); end
        checks++; if (d_vs !== 1'b1)   begin failures++; $display("FAIL reset_vsync got %b want 1", d_vs); end
        checks++; if (d_ve !== 1'b1)   begin failures++; $display("FAIL reset_video_en got %b want 1", d_ve); end
        checks++; if (d_fs !== 1'b0)   begin failures++; $display("FAIL reset_frame_start got %b want 0", d_fs); end
        checks++; if (d_ls !== 1'b0)   begin failures++; $display("FAIL reset_line_start got %b want 0", d_ls); end
        checks++; if (f_tick !== 1'b0) begin failures++; $display("FAIL reset_fast_tick got %b want 0", f_tick); end
    endtask

    // First pixels after release: tick spacing and hold time of pixel_x.
    task automatic test_pixel_steps();
        exp_t e;
        do_release();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            e = exp_def(n);
            checks++; if (d_tick !== e.tick) begin failures++; $display("FAIL steps_tick n=%0d got %b want %b", n, d_tick, e.tick); end
            checks++; if (int'(d_x) !== e.x) begin failures++; $display("FAIL steps_x n=%0d got %0d want %0d", n, d_x, e.x); end
        end
    endtask

    // Rest of the first full-size line and the entry into the next one.
    task automatic test_line();
        exp_t e;
        int   hs_low = 0, ls_seen = 0, ls_want = 0;
        for (int i = 0; i < 3190; i++) begin
            @(negedge clk);
            e = exp_def(n);
            if (d_hs === 1'b0) hs_low++;
            if (d_ls === 1'b1) ls_seen++;
            if (e.ls) ls_want++;
            checks++; if (int'(d_x) !== e.x) begin failures++; $display("FAIL line_x n=%0d got %0d want %0d", n, d_x, e.x); end
            checks++; if (d_hs !== e.hs) begin failures++; $display("FAIL line_hsync n=%0d x=%0d got %b want %b", n, d_x, d_hs, e.hs); end
            checks++; if (d_ve !== e.ve) begin failures++; $display("FAIL line_video_en n=%0d x=%0d got %b want %b", n, d_x, d_ve, e.ve); end
            checks++; if (d_ls !== e.ls) begin failures++; $display("FAIL line_start n=%0d got %b want %b", n, d_ls, e.ls); end
        end
        checks++; if (hs_low !== HSW_D * CD_D) begin failures++; $display("FAIL line_hsync_width got %0d clks want %0d", hs_low, HSW_D * CD_D); end
        checks++; if (ls_seen !== ls_want) begin failures++; $display("FAIL line_start_count got %0d want %0d", ls_seen, ls_want); end
    endtask

    // Two small frames at 4 clks/pixel and eight at 1 clk/pixel, every output every clk.
    task automatic test_frame();
        exp_t   e, g;
        int     vs_low = 0, fs_fast = 0, y_wraps = 0;
        longint first_fs = -1;
        logic [3:0] prev_y;
        do_reset();
        do_release();
        prev_y = s_y;
        for (int i = 0; i < 2 * HT_S * VT_S * CD_S + 8; i++) begin
            @(negedge clk);
            e = exp_sml(n);
            g = exp_fst(n);
            if (s_vs === 1'b0) vs_low++;
            if (f_fs === 1'b1) fs_fast++;
            if ((s_fs === 1'b1) && (first_fs < 0)) first_fs = n;
            if ((prev_y == 4'(VT_S - 1)) && (s_y == 4'd0)) y_wraps++;
            prev_y = s_y;
            checks++; if (s_tick !== e.tick) begin failures++; $display("FAIL frame_s_tick n=%0d got %b want %b", n, s_tick, e.tick); end
            checks++; if (int'(s_x) !== e.x) begin failures++; $display("FAIL frame_s_x n=%0d got %0d want %0d", n, s_x, e.x); end
            checks++; if (int'(s_y) !== e.y) begin failures++; $display("FAIL frame_s_y n=%0d got %0d want %0d", n, s_y, e.y); end
            checks++; if (s_hs !== e.hs) begin failures++; $display("FAIL frame_s_hsync n=%0d got %b want %b", n, s_hs, e.hs); end
            checks++; if (s_vs !== e.vs) begin failures++; $display("FAIL frame_s_vsync n=%0d got %b want %b", n, s_vs, e.vs); end
            checks++; if (s_ve !== e.ve) begin failures++; $display("FAIL frame_s_video_en n=%0d got %b want %b", n, s_ve, e.ve); end
            checks++; if (s_fs !== e.fs) begin failures++; $display("FAIL frame_s_frame_start n=%0d got %b want %b", n, s_fs, e.fs); end
            checks++; if (s_ls !== e.ls) begin failures++; $display("FAIL frame_s_line_start n=%0d got %b want %b", n, s_ls, e.ls); end
            checks++; if (f_tick !== g.tick) begin failures++; $display("FAIL frame_f_tick n=%0d got %b want %b", n, f_tick, g.tick); end
            checks++; if (int'(f_x) !== g.x) begin failures++; $display("FAIL frame_f_x n=%0d got %0d want %0d", n, f_x, g.x); end
            checks++; if (int'(f_y) !== g.y) begin failures++; $display("FAIL frame_f_y n=%0d got %0d want %0d", n, f_y, g.y); end
            checks++; if (f_hs !== g.hs) begin failures++; $display("FAIL frame_f_hsync n=%0d got %b want %b", n, f_hs, g.hs); end
            checks++; if (f_vs !== g.vs) begin failures++; $display("FAIL frame_f_vsync n=%0d got %b want %b", n, f_vs, g.vs); end
            checks++; if (f_ve !== g.ve) begin failures++; $display("FAIL frame_f_video_en n=%0d got %b want %b", n, f_ve, g.ve); end
            checks++; if (f_fs !== g.fs) begin failures++; $display("FAIL frame_f_frame_start n=%0d got %b want %b", n, f_fs, g.fs); end
            checks++; if (f_ls !== g.ls) begin failures++; $display("FAIL frame_f_line_start n=%0d got %b want %b", n, f_ls, g.ls); end
        end
        checks++; if (vs_low !== 2 * VSW_S * HT_S * CD_S) begin failures++; $display("FAIL frame_vsync_width got %0d clks want %0d", vs_low, 2 * VSW_S * HT_S * CD_S); end
        checks++; if (first_fs !== longint'(HT_S * VT_S * CD_S)) begin failures++; $display("FAIL frame_first_start got n=%0d want %0d", first_fs, HT_S * VT_S * CD_S); end
        checks++; if (fs_fast !== 8) begin failures++; $display("FAIL frame_fast_count got %0d want 8", fs_fast); end
        checks++; if (y_wraps !== 2) begin failures++; $display("FAIL frame_y_wraps got %0d want 2", y_wraps); end
    endtask

    // Reset asserted between edges at divider phase 2, then restart timing.
    task automatic test_async_reset();
        exp_t   e;
        int     pix;
        longint target, first_fs, first_tick;
        for (int it = 0; it < 3; it++) begin
            pix    = (it == 0) ? (5 * HT_S + 12) : int'($urandom_range(HT_S * VT_S - 2, 1));
            target = longint'(pix) * CD_S + 2;
            do_reset();
            do_release();
            repeat (int'(target)) @(posedge clk);
            #2;
            e = exp_sml(n);
            checks++; if (int'(s_x) !== e.x || int'(s_y) !== e.y) begin failures++; $display("FAIL async_pre_pos got (%0d,%0d) want (%0d,%0d)", s_x, s_y, e.x, e.y); end
            rst_n = 1'b0;
            #1;
            checks++; if (s_x !== 5'd0 || s_y !== 4'd0) begin failures++; $display("FAIL async_pos got (%0d,%0d) want (0,0)", s_x, s_y); end
            checks++; if (s_hs !== 1'b1 || s_vs !== 1'b1 || s_ve !== 1'b1) begin failures++; $display("FAIL async_sync got hs=%b vs=%b ve=%b want 1 1 1", s_hs, s_vs, s_ve); end
            checks++; if (s_tick !== 1'b0 || s_fs !== 1'b0 || s_ls !== 1'b0) begin failures++; $display("FAIL async_pulses got tick=%b fs=%b ls=%b want 0 0 0", s_tick, s_fs, s_ls); end
            checks++; if (d_x !== 10'd0 || d_tick !== 1'b0 || f_tick !== 1'b0) begin failures++; $display("FAIL async_others got dx=%0d dt=%b ft=%b want 0 0 0", d_x, d_tick, f_tick); end
            @(negedge clk);
            rst_n      = 1'b1;
            first_fs   = -1;
            first_tick = -1;
            for (int i = 0; i < HT_S * VT_S * CD_S + 4; i++) begin
                @(negedge clk);
                e = exp_sml(n);
                if ((s_tick === 1'b1) && (first_tick < 0)) first_tick = n;
                if ((s_fs === 1'b1) && (first_fs < 0)) first_fs = n;
                checks++; if (s_tick !== e.tick || s_fs !== e.fs) begin failures++; $display("FAIL async_restart n=%0d got tick=%b fs=%b want %b %b", n, s_tick, s_fs, e.tick, e.fs); end
            end
            checks++; if (first_tick !== longint'(CD_S)) begin failures++; $display("FAIL async_first_tick got n=%0d want %0d", first_tick, CD_S); end
            checks++; if (first_fs !== longint'(HT_S * VT_S * CD_S)) begin failures++; $display("FAIL async_first_frame got n=%0d want %0d", first_fs, HT_S * VT_S * CD_S); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_pixel_steps();
        test_line();
        test_frame();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
